// File: rtl/ssd_mux_driver.sv
`timescale 1ns/1ps
// Binary -> BCD (sequential double-dabble) feeding a multiplexed common-anode 7-segment scan.
// Latency: load edge k -> done pulse after edge k+BIN_W+1; the scan runs continuously and independently.
// Backpressure: busy=1 while converting; a load during busy is dropped, never queued.
module ssd_mux_driver #(
    parameter int DIGITS      = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 100000,
    parameter int LEAD_BLANK  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  bin_in,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [6:0]        cathodes,
    output logic [DIGITS-1:0] anodes
);
    localparam int BW = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = $clog2(BIN_W + 1);
    localparam logic [63:0] MAXV = 64'(10 ** DIGITS) - 64'd1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    adj;
    logic [BIN_W-1:0] bin_sr;
    logic [SW-1:0]    step;
    logic             ovf_pend;
    logic [BW-1:0]    disp;

    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    msn;
    logic [3:0]       cur;
    logic [6:0]       pat;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'd0:    font = 7'b1000000;
            4'd1:    font = 7'b1111001;
            4'd2:    font = 7'b0100100;
            4'd3:    font = 7'b0110000;
            4'd4:    font = 7'b0011001;
            4'd5:    font = 7'b0010010;
            4'd6:    font = 7'b0000010;
            4'd7:    font = 7'b1111000;
            4'd8:    font = 7'b0000000;
            4'd9:    font = 7'b0010000;
            default: font = 7'b1111111;
        endcase
    endfunction

    // Add-3 correction is applied before the shift of the same cycle.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            ovf_pend <= 1'b0;
            bcd      <= '0;
            bin_sr   <= '0;
            step     <= '0;
            disp     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr   <= bin_in;
                        bcd      <= '0;
                        ovf_pend <= (64'(bin_in) > MAXV);
                        step     <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {adj, bin_sr} << 1;
                    step          <= step + 1'b1;
                    if (step == SW'(BIN_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    disp  <= bcd;
                    ovf   <= ovf_pend;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // msn = most significant nonzero digit (0 when the value is zero).
    always_comb begin
        msn = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (disp[i*4 +: 4] != 4'd0)
                msn = IW'(i);
        end
        cur = disp[int'(idx)*4 +: 4];
        if (ovf)
            pat = 7'b0111111;
        else if (LEAD_BLANK != 0 && idx > msn)
            pat = 7'b1111111;
        else
            pat = font(cur);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            anodes   <= '1;
            cathodes <= 7'b1111111;
        end else begin
            if (cnt == CW'(REFRESH_DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            anodes   <= ~(DIGITS'(1) << idx);
            cathodes <= pat;
        end
    end
endmodule
